sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 The block SHALL have ports: clk  input  1  rising-edge system clock.
REQ-002 The block SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 The block SHALL have ports: wr_en  input  1  MEM-stage store request, level-held until ready.
REQ-004 The block SHALL have ports: rd_en  input  1  MEM-stage load request, level-held until ready.
REQ-005 The block SHALL have ports: address  input  32  byte address of the word access.
REQ-006 The block SHALL have ports: write_data  input  32  store data.
REQ-007 The block SHALL have ports: read_data  output  32  load data, registered.
REQ-008 The block SHALL have ports: ready  output  1  access complete; low = freeze the pipeline.
REQ-009 The block SHALL have ports: SRAM_DQ  inout  16  SRAM data bus.
REQ-010 The block SHALL have ports: SRAM_ADDR  output  18  SRAM half-word address.
REQ-011 The block SHALL have ports: SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  output  1 each  SRAM strobes, active-low.

Function
REQ-012 The FSM SHALL have states IDLE, LOW, HIGH and DONE.
REQ-013 Transitions SHALL be: IDLE -> LOW when (rd_en | wr_en); LOW -> HIGH; HIGH -> DONE; DONE -> IDLE unconditionally.
REQ-014 If both rd_en and wr_en are high in IDLE, the access SHALL be a write. The operation type and address SHALL be latched on leaving IDLE.
REQ-015 Word index SHALL be idx = (address - 32'd1024) >> 2. SRAM_ADDR SHALL be {idx[16:0],1'b0} in LOW and {idx[16:0],1'b1} in HIGH; higher idx bits are ignored.
REQ-016 SRAM_CE_N, SRAM_OE_N, SRAM_UB_N and SRAM_LB_N SHALL be 0 constantly.
REQ-017 SRAM_WE_N SHALL be 0 only in LOW/HIGH of a write, and 1 otherwise.
REQ-018 SRAM_DQ SHALL carry write_data[15:0] in LOW and write_data[31:16] in HIGH of a write, and SHALL be high-Z in all other cases.
REQ-019 For a read, read_data[15:0] SHALL capture SRAM_DQ at the clock edge ending LOW, and read_data[31:16] at the edge ending HIGH. read_data SHALL hold its value otherwise.
REQ-020 ready SHALL be ~(rd_en | wr_en) in IDLE, 0 in LOW/HIGH, and 1 in DONE (combinational from state and enables).
REQ-021 Latency: request seen in IDLE at cycle 0 SHALL give ready=1 in cycle 3, with read_data valid in that cycle.
REQ-022 Deasserting rd_en/wr_en mid-access SHALL NOT abort the access; it completes through DONE.
REQ-023 A request still present in IDLE after DONE SHALL start a new access (back-to-back; no idle gap beyond the IDLE cycle).

Reset
REQ-024 While rst is high: state = IDLE, read_data = 0, SRAM_WE_N = 1, SRAM_DQ = high-Z, and SRAM_ADDR = 0, all applied asynchronously.
REQ-025 rst asserted mid-write SHALL release SRAM_WE_N immediately. The aborted access SHALL NOT resume after reset.

Configuration
REQ-026 Macro SRAM_CTRL_WAIT_EN, when defined, SHALL hold each of LOW and HIGH for 2 cycles using an internal 1-bit wait counter. Address, WE_N and DQ SHALL be stable over both cycles, read capture SHALL occur on the second edge, and ready SHALL rise in cycle 5.
REQ-027 Without SRAM_CTRL_WAIT_EN, timing SHALL be exactly as in REQ-021, with no wait counter present.

Verification
REQ-028 Write: wr_en=1, address=1024, write_data=32'hDEAD_BEEF -> SRAM half-word 0 = 16'hBEEF and 1 = 16'hDEAD; ready=1 in cycle 3.
REQ-029 Read-back: rd_en=1, address=1024 after REQ-028 -> read_data=32'hDEAD_BEEF with ready=1 in cycle 3. SRAM_WE_N stays 1 throughout.
REQ-030 Address map: write at address=1028 -> SRAM_ADDR=2 then 3. Read at address=1024 is unaffected.
REQ-031 Both enables: rd_en=wr_en=1, address=1032, write_data=32'h1234_5678 -> write performed, SRAM halves 4/5 = 5678/1234.
REQ-032 Reset mid-write: rst pulse during HIGH -> SRAM_WE_N=1 and SRAM_DQ=Z within the same cycle, state IDLE, ready follows enables.
REQ-033 With SRAM_CTRL_WAIT_EN: REQ-028/029 repeated -> same data, ready=1 in cycle 5.

Source files
------------

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//   Bridges a 32-bit MEM-stage load/store port onto a 16-bit asynchronous
//   SRAM. Each word access is split into two half-word cycles (LOW, then
//   HIGH), followed by a DONE cycle in which ready is raised. While an access
//   is in flight, ready is low so the pipeline stays frozen.
//
//   Optional build macro: SRAM_CTRL_WAIT_EN
//     When defined, LOW and HIGH each last two clock cycles, which gives slow
//     SRAM parts more access time. A 1-bit wait counter paces the phases.
//     When undefined, each phase lasts one cycle and there is no counter.
//
// Ports
//   clk          in   rising-edge system clock
//   rst          in   asynchronous active-high reset
//   wr_en        in   store request, held until ready
//   rd_en        in   load request, held until ready (a write wins if both)
//   address      in   byte address of the word (SRAM window starts at 1024)
//   write_data   in   store data
//   read_data    out  registered load data
//   ready        out  access complete; low freezes the pipeline
//   SRAM_DQ      io   16-bit SRAM data bus
//   SRAM_ADDR    out  SRAM half-word address
//   SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
//                out  active-low SRAM strobes
// ---------------------------------------------------------------------------
module sram_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  logic [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [16:0] idx_q, idx_d;
  logic [31:0] read_data_q, read_data_d;

  // Phase advance: each half-word phase ends when step is high.
  logic        step;

`ifdef SRAM_CTRL_WAIT_EN
  logic        wait_q, wait_d;
  assign step = wait_q;
`else
  assign step = 1'b1;
`endif

  // Word index relative to the start of the SRAM window. Only 17 index bits
  // reach the 18-bit half-word address; the rest are deliberately dropped.
  logic [31:0] addr_off;
  assign addr_off = address - 32'd1024;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      idx_q       <= '0;
      read_data_q <= '0;
`ifdef SRAM_CTRL_WAIT_EN
      wait_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      idx_q       <= idx_d;
      read_data_q <= read_data_d;
`ifdef SRAM_CTRL_WAIT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    idx_d       = idx_q;
    read_data_d = read_data_q;
`ifdef SRAM_CTRL_WAIT_EN
    // Toggles through each phase so the phase ends on its second cycle.
    wait_d      = 1'b0;
    if (state_q == LOW || state_q == HIGH) begin
      wait_d = ~wait_q;
    end
`endif
    case (state_q)
      IDLE: begin
        if (rd_en | wr_en) begin
          state_d = LOW;
          is_wr_d = wr_en;
          idx_d   = addr_off[18:2];
        end
      end
      LOW: begin
        if (step) begin
          state_d = HIGH;
          if (!is_wr_q) begin
            read_data_d[15:0] = SRAM_DQ;
          end
        end
      end
      HIGH: begin
        if (step) begin
          state_d = DONE;
          if (!is_wr_q) begin
            read_data_d[31:16] = SRAM_DQ;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic        dq_oe;
  logic [15:0] dq_out;

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    ready     = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~(rd_en | wr_en);
      end
      LOW: begin
        SRAM_ADDR = {idx_q, 1'b0};
        SRAM_WE_N = ~is_wr_q;
        dq_oe     = is_wr_q;
        dq_out    = write_data[15:0];
      end
      HIGH: begin
        SRAM_ADDR = {idx_q, 1'b1};
        SRAM_WE_N = ~is_wr_q;
        dq_oe     = is_wr_q;
        dq_out    = write_data[31:16];
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign read_data = read_data_q;

  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
//   Directed and randomized word accesses against sram_ctrl with a
//   behavioural SRAM attached. Expected data comes from a word-level
//   reference array; expected timing comes from the phase length (1 or 2
//   cycles) and the resulting ready latency.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

`ifdef SRAM_CTRL_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 1;
`endif
  localparam int LAT = 2 * W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n),
    .SRAM_WE_N (sram_we_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_OE_N (sram_oe_n)
  );

  // Behavioural SRAM: 1024 half-words, written while WE_N is low, driven
  // onto the bus only when the bench expects a read.
  logic [15:0] sram_mem [0:1023];
  logic        model_oe = 1'b0;
  assign sram_dq = (model_oe && sram_we_n) ? sram_mem[sram_addr[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[9:0]] <= sram_dq;
  end

  // Word-level reference contents, indexed by the low 9 word-index bits.
  logic [31:0] ref_words [0:511];
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access starting in IDLE (just after a rising edge).
  // hold: keep the request asserted after DONE (back-to-back).
  // drop: release the request after the first cycle of the access.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input bit hold, input bit drop);
    logic [31:0] off;
    logic [17:0] base;
    logic [8:0]  widx;
    int          half;
    off  = addr - 32'd1024;
    base = {off[18:2], 1'b0};
    widx = off[10:2];
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    model_oe = rd && !wr;
    #1;
    chk("ready_idle_req", {31'd0, ready}, 32'd0);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      if (c < LAT) begin
        half = (c - 1) / W;
        chk("sram_addr", {14'd0, sram_addr}, {14'd0, base | 18'(half)});
        chk("we_n", {31'd0, sram_we_n}, {31'd0, !wr});
        if (wr) chk("dq_drive", {16'd0, sram_dq}, {16'd0, half ? data[31:16] : data[15:0]});
        chk("ready_busy", {31'd0, ready}, 32'd0);
      end else begin
        chk("ready_done", {31'd0, ready}, 32'd1);
        chk("we_n_done", {31'd0, sram_we_n}, 32'd1);
        if (wr) begin
          ref_words[widx] = data;
          chk("rd_hold", read_data, last_rd);
        end else begin
          last_rd = ref_words[widx];
          chk("read_data", read_data, last_rd);
        end
      end
      if (drop && c == 1) begin
        wr_en = 1'b0; rd_en = 1'b0;
      end
    end
    if (!hold) begin
      wr_en = 1'b0; rd_en = 1'b0; model_oe = 1'b0;
    end
    @(posedge clk); #1;
    if (!hold) chk("ready_idle", {31'd0, ready}, 32'd1);
    $display("[TB] access wr=%0b rd=%0b addr=%h data=%h read_data=%h", wr, rd, addr, data, read_data);
  endtask

  initial begin
    logic [31:0] a, d;
    int          idx;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    last_rd = '0;
    #2;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("strobes", {27'd0, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n, 1'b0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic write and read-back
    access(1, 0, 32'd1024, 32'hDEAD_BEEF, 0, 0);
    chk("mem_h0", {16'd0, sram_mem[0]}, 32'h0000_BEEF);
    chk("mem_h1", {16'd0, sram_mem[1]}, 32'h0000_DEAD);
    access(0, 1, 32'd1024, 32'h0, 0, 0);
    // Address map: next word lands on half-words 2/3
    access(1, 0, 32'd1028, 32'hCAFE_F00D, 0, 0);
    access(0, 1, 32'd1024, 32'h0, 0, 0);
    access(0, 1, 32'd1028, 32'h0, 0, 0);
    // Both enables: write wins
    access(1, 1, 32'd1032, 32'h1234_5678, 0, 0);
    chk("mem_h4", {16'd0, sram_mem[4]}, 32'h0000_5678);
    chk("mem_h5", {16'd0, sram_mem[5]}, 32'h0000_1234);
    access(0, 1, 32'd1032, 32'h0, 0, 0);
    // Index bit 17 is dropped: aliases onto word 5
    access(1, 0, 32'd1024 + 32'd4 * (32'd131072 + 32'd5), 32'h0BAD_F00D, 0, 0);
    access(0, 1, 32'd1044, 32'h0, 0, 0);
    // Request released mid-access still completes
    access(1, 0, 32'd1024 + 32'd4 * 32'd7, 32'h7777_1111, 0, 1);
    access(0, 1, 32'd1024 + 32'd4 * 32'd7, 32'h0, 0, 1);
    // Back-to-back: write then read with no idle gap
    access(1, 0, 32'd1024 + 32'd4 * 32'd40, 32'h4040_0404, 1, 0);
    access(0, 1, 32'd1024 + 32'd4 * 32'd40, 32'h0, 0, 0);

    // Reset during HIGH of a write
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1024 + 32'd4 * 32'd20;
    write_data = 32'hA5A5_5A5A; model_oe = 1'b0;
    repeat (W + 1) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_addr", {14'd0, sram_addr}, 32'd41);
    chk("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
    n_tests++;
    assert (sram_dq !== 16'hA5A5) else begin
      n_fail++;
      $error("FAIL mid_rst_dq: got %h expected released bus", sram_dq);
    end
    chk("mid_rst_read_data", read_data, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    #1;
    chk("rst_ready_follow", {31'd0, ready}, 32'd1);
    rst = 1'b0;
    last_rd = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_rst_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("post_rst_ready", {31'd0, ready}, 32'd1);
    end
    $display("[TB] reset mid-write done, we_n=%0b addr=%h", sram_we_n, sram_addr);

    // Randomized traffic over word indices 32..63
    for (int i = 0; i < 24; i++) begin
      idx = 32 + int'($urandom_range(31, 0));
      a   = 32'd1024 + 32'(idx) * 32'd4;
      d   = $urandom;
      access(1, 0, a, d, 0, 0);
      idx = 32 + int'($urandom_range(31, 0));
      a   = 32'd1024 + 32'(idx) * 32'd4;
      if (ref_words[idx[8:0]] !== 32'hxxxx_xxxx) begin
        access(0, 1, a, 32'h0, $urandom_range(1, 0) == 1, 0);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0; model_oe = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
